// File: rtl/uart_parity_rx.sv
// Serial frame receiver (start, 8 data LSB-first, parity, stop) with parity and framing checks.
// All frame decisions use the synchronised line; results are presented with a one-cycle valid pulse.
module uart_parity_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       parity_type,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t      state;
    logic [1:0]  rx_sync;
    logic        rx_s;
    logic [15:0] cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        par_type_l;
    logic        par_err_q;
    logic [1:0]  vld_pipe;
    logic        mid_bit;
    logic        exp_par;

    assign rx_s       = rx_sync[1];
    assign mid_bit    = (cnt == BIT_LAST);
    assign exp_par    = par_type_l ? ^shreg : ~^shreg;
    assign data_valid = vld_pipe[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_type_l <= 1'b0;
            par_err_q  <= 1'b0;
            vld_pipe   <= '0;
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // stop-bit sample lands in vld_pipe[0]; the visible pulse follows one cycle later
            vld_pipe <= {vld_pipe[0], 1'b0};
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state      <= DATA;
                            par_type_l <= parity_type;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (mid_bit) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PARITY: begin
                    if (mid_bit) begin
                        cnt       <= '0;
                        par_err_q <= (rx_s != exp_par);
                        state     <= STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (mid_bit) begin
                        cnt         <= '0;
                        data_out    <= shreg;
                        parity_err  <= par_err_q;
                        frame_err   <= ~rx_s;
                        vld_pipe[0] <= 1'b1;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_IDLE: begin
                    // a held-low line (break) must not look like a fresh start bit
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_parity_rx.sv
// Directed bench for uart_parity_rx: clean frames, parity/framing errors, glitch and mid-frame reset.
module tb_uart_parity_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       parity_type;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int vcount = 0;
    int multi = 0;
    int last_vcyc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] cap_data = '0;
    logic cap_pe = 1'b0;
    logic cap_fe = 1'b0;

    uart_parity_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .parity_type(parity_type),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            vcount    <= vcount + 1;
            last_vcyc <= cyc;
            cap_data  <= data_out;
            cap_pe    <= parity_err;
            cap_fe    <= frame_err;
            if (prev_valid) multi <= multi + 1;
        end
        prev_valid <= data_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int v0;
    int t0;

    initial begin
        rst = 1'b1;
        rx_in = 1'b1;
        parity_type = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_data", data_out, 8'h00);
        check("reset_valid", data_valid, 0);
        check("reset_pe", parity_err, 0);
        check("reset_fe", frame_err, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        idle(5);

        // T1: even parity, 0xA5 has four ones -> parity bit 0
        v0 = vcount;
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(4);
        check("t1_count", vcount - v0, 1);
        check("t1_data", cap_data, 8'hA5);
        check("t1_pe", cap_pe, 0);
        check("t1_fe", cap_fe, 0);
        check("t1_latency_ok", ((last_vcyc - t0) >= 170 && (last_vcyc - t0) <= 172), 1);
        check("t1_busy_low", busy, 0);
        check("t1_single_pulse", multi, 0);

        // T2: wrong parity bit
        v0 = vcount;
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(4);
        check("t2_count", vcount - v0, 1);
        check("t2_data", cap_data, 8'hA5);
        check("t2_pe", cap_pe, 1);
        check("t2_fe", cap_fe, 0);

        // T3: odd parity
        parity_type = 1'b0;
        v0 = vcount;
        send_frame(8'h01, 1'b0, 1'b1);
        idle(4);
        check("t3a_data", cap_data, 8'h01);
        check("t3a_pe", cap_pe, 0);
        send_frame(8'h03, 1'b0, 1'b1);
        idle(4);
        check("t3b_data", cap_data, 8'h03);
        check("t3b_pe", cap_pe, 1);
        check("t3_count", vcount - v0, 2);

        // T4: framing error with line held low afterwards; type flips mid-frame
        parity_type = 1'b1;
        v0 = vcount;
        send_bit(1'b0);
        parity_type = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(logic'((8'h3C >> i) & 1));
        send_bit(1'b0);
        send_bit(1'b0);
        rx_in = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("t4_count", vcount - v0, 1);
        check("t4_data", cap_data, 8'h3C);
        check("t4_fe", cap_fe, 1);
        check("t4_pe", cap_pe, 0);
        check("t4_busy_wait", busy, 1);
        idle(6);
        check("t4_busy_release", busy, 0);
        check("t4_no_retrigger", vcount - v0, 1);
        parity_type = 1'b1;
        send_frame(8'h55, 1'b0, 1'b1);
        idle(4);
        check("t4_next_count", vcount - v0, 2);
        check("t4_next_data", cap_data, 8'h55);
        check("t4_next_pe", cap_pe, 0);
        check("t4_next_fe", cap_fe, 0);

        // T5: short glitch
        v0 = vcount;
        rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (CPB / 2 + 3) @(posedge clk);
        #1;
        check("t5_busy", busy, 0);
        idle(CPB * 12);
        check("t5_no_valid", vcount - v0, 0);

        // T6: reset during data bit 4 of 0xF0
        v0 = vcount;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx_in = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(CPB * 8);
        check("t6_no_valid", vcount - v0, 0);
        check("t6_data", data_out, 8'h00);
        check("t6_pe", parity_err, 0);
        check("t6_fe", frame_err, 0);
        check("t6_busy", busy, 0);
        send_frame(8'h81, 1'b0, 1'b1);
        idle(4);
        check("t6_next_count", vcount - v0, 1);
        check("t6_next_data", cap_data, 8'h81);
        check("t6_next_pe", cap_pe, 0);
        check("t6_next_fe", cap_fe, 0);
        check("all_single_pulse", multi, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
